// File: rtl/warp_rocc_host.sv
// warp_rocc_host: host-side RoCC command initiator for warp_engine.
// Takes one host command at a time, issues it on the RoCC cmd channel, waits
// for the matching resp beat, then returns data plus an error code to the host.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   host_req_*                 host command (valid/ready, funct, rd, rs1/rs2 data)
//   host_rsp_*                 host result (valid/ready, data, rd, err)
//   cmd_*                      RoCC command channel towards the engine
//   resp_*                     RoCC response channel from the engine
//   busy                       transaction in flight
//   cmd_count, err_count       saturating ok / error completion counters
module warp_rocc_host #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CMD_TIMEOUT  = 100,
  parameter int unsigned RESP_TIMEOUT = 10000,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic [6:0]            host_req_funct,
  input  logic [4:0]            host_req_rd,
  input  logic [DATA_WIDTH-1:0] host_req_rs1_data,
  input  logic [DATA_WIDTH-1:0] host_req_rs2_data,
  output logic                  host_rsp_valid,
  input  logic                  host_rsp_ready,
  output logic [DATA_WIDTH-1:0] host_rsp_data,
  output logic [4:0]            host_rsp_rd,
  output logic [1:0]            host_rsp_err,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [6:0]            cmd_funct,
  output logic [4:0]            cmd_rs1,
  output logic [4:0]            cmd_rs2,
  output logic [4:0]            cmd_rd,
  output logic [DATA_WIDTH-1:0] cmd_rs1_data,
  output logic [DATA_WIDTH-1:0] cmd_rs2_data,
  input  logic                  resp_valid,
  output logic                  resp_ready,
  input  logic [4:0]            resp_rd,
  input  logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  cmd_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int unsigned FUNCT_W = 7;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ERR_W   = 2;
  localparam int unsigned TMR_MAX = (CMD_TIMEOUT > RESP_TIMEOUT) ? CMD_TIMEOUT : RESP_TIMEOUT;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);

  localparam logic [ERR_W-1:0] ERR_OK      = 2'b00;
  localparam logic [ERR_W-1:0] ERR_CMD_TO  = 2'b01;
  localparam logic [ERR_W-1:0] ERR_RESP_TO = 2'b10;
  localparam logic [ERR_W-1:0] ERR_RD_MISM = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RESP, S_REPORT} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d, timer_inc;
  logic [FUNCT_W-1:0]      funct_q, funct_d;
  logic [REG_W-1:0]        rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [ERR_W-1:0]        rsp_err_q, rsp_err_d;
  logic [CNT_WIDTH-1:0]    cmd_cnt_q, cmd_cnt_d, err_cnt_q, err_cnt_d;

  assign timer_inc = timer_q + TW'(1);

  // Next-state, latches, timer and counters
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    funct_d    = funct_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cmd_cnt_d  = cmd_cnt_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (host_req_valid) begin
          funct_d = host_req_funct;
          rd_d    = host_req_rd;
          rs1_d   = host_req_rs1_data;
          rs2_d   = host_req_rs2_data;
          timer_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Handshake has priority over an expiry in the same cycle
        if (cmd_valid_q && cmd_ready) begin
          timer_d = '0;
          state_d = S_WAIT_RESP;
        end else if (timer_inc == TW'(CMD_TIMEOUT)) begin
          rsp_err_d  = ERR_CMD_TO;
          rsp_data_d = '0;
          state_d    = S_REPORT;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT_RESP: begin
        if (resp_valid) begin
          rsp_data_d = resp_data;
          rsp_err_d  = (resp_rd != rd_q) ? ERR_RD_MISM : ERR_OK;
          state_d    = S_REPORT;
        end else if (timer_inc == TW'(RESP_TIMEOUT)) begin
          rsp_err_d  = ERR_RESP_TO;
          rsp_data_d = '0;
          state_d    = S_REPORT;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_REPORT: begin
        if (host_rsp_ready) begin
          if (rsp_err_q == ERR_OK) begin
            if (cmd_cnt_q != '1) cmd_cnt_d = cmd_cnt_q + CNT_WIDTH'(1);
          end else begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Valids registered from the next state so they track state exactly
    cmd_valid_d = (state_d == S_ISSUE);
    rsp_valid_d = (state_d == S_REPORT);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      funct_q     <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      cmd_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
      cmd_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      funct_q     <= funct_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      cmd_valid_q <= cmd_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cmd_cnt_q   <= cmd_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // State decodes are gated by rst_n so they read 0 throughout reset
  assign host_req_ready = rst_n && (state_q == S_IDLE);
  assign resp_ready     = rst_n && (state_q == S_WAIT_RESP);
  assign busy           = rst_n && (state_q != S_IDLE);

  assign cmd_valid      = cmd_valid_q;
  assign cmd_funct      = funct_q;
  assign cmd_rd         = rd_q;
  assign cmd_rs1        = '0;
  assign cmd_rs2        = '0;
  assign cmd_rs1_data   = rs1_q;
  assign cmd_rs2_data   = rs2_q;

  assign host_rsp_valid = rsp_valid_q;
  assign host_rsp_data  = rsp_data_q;
  assign host_rsp_rd    = rd_q;
  assign host_rsp_err   = rsp_err_q;

  assign cmd_count      = cmd_cnt_q;
  assign err_count      = err_cnt_q;

endmodule
